// File: rtl/mix_columns_engine.sv
// mix_columns_engine: AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_mode/in_state accept a 128-bit state;
// out_valid/out_ready/out_state return the transformed state; busy is high while transforming.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int INV_EN         = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
    localparam logic       INV  = (INV_EN != 0);

    state_t          state;
    logic [1:0]      cnt;
    logic            mode;
    logic [3:0][31:0] work;
    logic [3:0][31:0] nxt;
    logic [1:0]      idx;

    assign out_state = work;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse is a pre-multiply by {05 00 04 00} followed by the forward matrix;
    // with INV_EN=0 the inv term is constant 0 and the pre-multiply disappears.
    function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
        logic [7:0] u, v, a0, a1, a2, a3;
        u  = inv ? xt(xt(c[31:24] ^ c[15:8])) : 8'h00;
        v  = inv ? xt(xt(c[23:16] ^ c[7:0])) : 8'h00;
        a0 = c[31:24] ^ u;
        a1 = c[23:16] ^ v;
        a2 = c[15:8] ^ u;
        a3 = c[7:0] ^ v;
        return {xt(a0 ^ a1) ^ a1 ^ a2 ^ a3,
                xt(a1 ^ a2) ^ a2 ^ a3 ^ a0,
                xt(a2 ^ a3) ^ a3 ^ a0 ^ a1,
                xt(a3 ^ a0) ^ a0 ^ a1 ^ a2};
    endfunction

    // Column c lives in work[3-c]; ~idx is 3-idx for a 2-bit index.
    always_comb begin
        nxt = work;
        idx = cnt;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            idx = cnt + 2'(k);
            nxt[~idx] = mix(nxt[~idx], mode & INV);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            mode      <= 1'b0;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work     <= in_state;
                    mode     <= in_mode & INV;
                    cnt      <= 2'd0;
                    state    <= BUSY;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                BUSY: begin
                    work <= nxt;
                    cnt  <= cnt + STEP;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: checks four engine configurations against a GF(2^8) matrix model.
module tb_mix_columns_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst[4], in_valid[4], in_mode[4], out_ready[4];
    logic         in_ready[4], out_valid[4], busy[4];
    logic [127:0] in_state[4], out_state[4];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_D4    = {4{32'hd4d4d4d5}};
    localparam logic [127:0] V_D5    = {4{32'hd5d5d7d6}};
    localparam logic [127:0] V_2D    = {4{32'h2d26314c}};
    localparam logic [127:0] V_4D    = {4{32'h4d7ebdf8}};

    function automatic int cpc_of(input int i);
        return i == 1 ? 2 : i == 2 ? 4 : 1;
    endfunction
    function automatic int inv_of(input int i);
        return i == 3 ? 0 : 1;
    endfunction
    function automatic int lat_of(input int i);
        return 4 / cpc_of(i);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mix_columns_engine #(
            .COLS_PER_CYCLE(g == 1 ? 2 : g == 2 ? 4 : 1),
            .INV_EN(g == 3 ? 0 : 1)
        ) dut (
            .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_mode(in_mode[g]), .in_state(in_state[g]), .out_valid(out_valid[g]),
            .out_ready(out_ready[g]), .out_state(out_state[g]), .busy(busy[g])
        );
    end

    task automatic chk(input string name, input int i, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cfg%0d: got %h expected %h", name, i, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product per column: out[r] = sum_k base[(k-r) mod 4] * a[k].
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   base[4];
        logic [7:0]   a[4];
        logic [7:0]   b;
        logic [127:0] r;
        base[0] = inv ? 8'h0e : 8'h02;
        base[1] = inv ? 8'h0b : 8'h03;
        base[2] = inv ? 8'h0d : 8'h01;
        base[3] = inv ? 8'h09 : 8'h01;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b ^= gmul(base[(k - rr + 4) % 4], a[k]);
                r[127-32*c-8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    // Scoreboard: per config, a pending result becomes visible lat cycles after acceptance.
    bit           pending[4];
    bit           known[4];
    int           ready_at[4];
    logic [127:0] m_exp[4], m_hold[4];

    always @(negedge clk) begin
        bit ov;
        for (int i = 0; i < 4; i++) begin
            ov = pending[i] && cyc >= ready_at[i];
            if (known[i]) begin
                chk("in_ready", i, 128'(in_ready[i]), 128'(!pending[i]));
                chk("busy", i, 128'(busy[i]), 128'(pending[i] && !ov));
                chk("out_valid", i, 128'(out_valid[i]), 128'(ov));
                if (ov) chk("out_state", i, out_state[i], m_exp[i]);
                else if (!pending[i]) chk("idle_state", i, out_state[i], m_hold[i]);
            end
            if (rst[i]) begin
                known[i]   = 1'b1;
                pending[i] = 1'b0;
                m_hold[i]  = '0;
            end else if (known[i] && !pending[i] && in_valid[i]) begin
                pending[i]  = 1'b1;
                ready_at[i] = cyc + 1 + lat_of(i);
                m_exp[i]    = ref_mix(in_state[i], in_mode[i] && inv_of(i) != 0);
            end else if (known[i] && ov && out_ready[i]) begin
                pending[i] = 1'b0;
                m_hold[i]  = m_exp[i];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic xfer(input int i, input logic [127:0] s, input logic m, input logic [127:0] exp, input string name);
        int k;
        in_state[i]  = s;
        in_mode[i]   = m;
        in_valid[i]  = 1'b1;
        out_ready[i] = 1'b1;
        step();
        in_valid[i] = 1'b0;
        in_state[i] = {$urandom, $urandom, $urandom, $urandom};
        in_mode[i]  = !m;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid[i] && k < 20);
        chk({name, "_latency"}, i, 128'(k), 128'(lat_of(i)));
        chk(name, i, out_state[i], exp);
        #1;
        step();
        step();
    endtask

    task automatic run(input int i);
        int           lat, n, k;
        int           t[3];
        logic [127:0] s;
        lat = lat_of(i);
        rst[i] = 1'b1;
        in_valid[i] = 1'b0;
        in_mode[i] = 1'b0;
        out_ready[i] = 1'b0;
        in_state[i] = '0;
        step();
        step();
        chk("rst_in_ready", i, 128'(in_ready[i]), 128'(1));
        chk("rst_out_valid", i, 128'(out_valid[i]), 128'(0));
        chk("rst_busy", i, 128'(busy[i]), 128'(0));
        chk("rst_out_state", i, out_state[i], '0);
        rst[i] = 1'b0;
        if (i == 3) xfer(i, V_2D, 1'b1, V_4D, "mode_isolation");
        else xfer(i, V_MIXED, 1'b1, V_PLAIN, "inverse_vec");
        xfer(i, V_PLAIN, 1'b0, V_MIXED, "forward_vec");
        // Backpressure: result must hold for 10 clocks with out_ready low.
        s = {$urandom, $urandom, $urandom, $urandom};
        in_state[i] = s;
        in_mode[i] = 1'b0;
        in_valid[i] = 1'b1;
        out_ready[i] = 1'b0;
        step();
        in_valid[i] = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (!out_valid[i] && k < 20);
        repeat (10) begin
            step();
            chk("bp_out_valid", i, 128'(out_valid[i]), 128'(1));
            chk("bp_in_ready", i, 128'(in_ready[i]), 128'(0));
            chk("bp_out_state", i, out_state[i], ref_mix(s, 1'b0));
        end
        out_ready[i] = 1'b1;
        step();
        chk("bp_release_out_valid", i, 128'(out_valid[i]), 128'(0));
        chk("bp_release_in_ready", i, 128'(in_ready[i]), 128'(1));
        // Back-to-back throughput.
        in_state[i] = V_D4;
        in_valid[i] = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                t[n] = cyc;
                n++;
            end
        end
        @(posedge clk);
        #2;
        in_valid[i] = 1'b0;
        chk("b2b_count", i, 128'(n), 128'(3));
        if (n == 3) begin
            chk("b2b_gap0", i, 128'(t[1] - t[0]), 128'(lat + 2));
            chk("b2b_gap1", i, 128'(t[2] - t[1]), 128'(lat + 2));
        end
        repeat (lat + 3) step();
        // Abort mid-operation.
        in_state[i] = {$urandom, $urandom, $urandom, $urandom};
        in_valid[i] = 1'b1;
        out_ready[i] = 1'b0;
        step();
        in_valid[i] = 1'b0;
        rst[i] = 1'b1;
        step();
        rst[i] = 1'b0;
        chk("abort_in_ready", i, 128'(in_ready[i]), 128'(1));
        chk("abort_out_valid", i, 128'(out_valid[i]), 128'(0));
        chk("abort_busy", i, 128'(busy[i]), 128'(0));
        chk("abort_out_state", i, out_state[i], '0);
        out_ready[i] = 1'b1;
        repeat (6) step();
        // Random traffic, including random mode, backpressure and occasional reset.
        repeat (400) begin
            in_valid[i]  = 1'($urandom_range(0, 1));
            in_mode[i]   = 1'($urandom_range(0, 1));
            in_state[i]  = {$urandom, $urandom, $urandom, $urandom};
            out_ready[i] = $urandom_range(0, 3) != 0;
            rst[i]       = $urandom_range(0, 63) == 0;
            step();
        end
        rst[i] = 1'b0;
        in_valid[i] = 1'b0;
        out_ready[i] = 1'b1;
        repeat (8) step();
    endtask

    initial begin
        chk("model_fwd", 0, ref_mix(V_PLAIN, 1'b0), V_MIXED);
        chk("model_inv", 0, ref_mix(V_MIXED, 1'b1), V_PLAIN);
        chk("model_d4", 0, ref_mix(V_D4, 1'b0), V_D5);
        chk("model_2d", 0, ref_mix(V_2D, 1'b0), V_4D);
        fork
            run(0);
            run(1);
            run(2);
            run(3);
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
